// File: rtl/vga_frame_reader.sv
// 640x480@60 VGA timing generator and frame-buffer reader.
// Linear read addresses out, registered RGB444/sync/DE pins two clocks later.
module vga_frame_reader #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [18:0] rd_addr,
  output logic        rd_en,
  input  logic [11:0] rd_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_VIS  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  typedef struct packed {
    logic vis;
    logic hs;
    logic vs;
    logic sof;
  } tim_t;

  logic          run;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          h_end;
  logic          v_end;
  tim_t          s0;
  tim_t          s1;

  assign h_end = (h == H_LAST);
  assign v_end = (v == V_LAST);

  // run holds stage 0 idle until the first edge after reset,
  // so (0,0) is presented in the first post-reset cycle.
  always_comb begin
    s0     = '0;
    s0.vis = run && (h < H_VIS) && (v < V_VIS);
    s0.hs  = run && (h >= H_SS) && (h < H_SE);
    s0.vs  = run && (v >= V_SS) && (v < V_SE);
    s0.sof = run && (h == '0) && (v == '0);
  end

  assign rd_en = s0.vis;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run     <= 1'b0;
      h       <= '0;
      v       <= '0;
      rd_addr <= '0;
    end else begin
      run <= 1'b1;
      if (run) begin
        if (h_end) begin
          h <= '0;
          v <= v_end ? '0 : v + 1'b1;
        end else begin
          h <= h + 1'b1;
        end
        if (h_end && v_end) begin
          rd_addr <= '0;
        end else if (s0.vis) begin
          rd_addr <= rd_addr + 19'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
    end else begin
      s1 <= s0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_r       <= '0;
      vga_g       <= '0;
      vga_b       <= '0;
      vga_de      <= 1'b0;
      vga_hsync   <= ~SYNC_POL;
      vga_vsync   <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      {vga_r, vga_g, vga_b} <= s1.vis ? rd_data : 12'h000;
      vga_de      <= s1.vis;
      vga_hsync   <= s1.hs ? SYNC_POL : ~SYNC_POL;
      vga_vsync   <= s1.vs ? SYNC_POL : ~SYNC_POL;
      frame_start <= s1.sof;
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a reduced raster.
// Expected pins are queued per cycle and compared two clocks later.
module tb_vga_frame_reader;

  localparam int HA = 20;
  localparam int HFP = 4;
  localparam int HS = 6;
  localparam int HBP = 5;
  localparam int VA = 10;
  localparam int VFP = 2;
  localparam int VS = 2;
  localparam int VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;
  localparam logic [15:0] BLANK = 16'h6000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [18:0] rd_addr;
  logic        rd_en;
  logic [11:0] rd_data = '0;
  logic [3:0]  vga_r;
  logic [3:0]  vga_g;
  logic [3:0]  vga_b;
  logic        vga_hsync;
  logic        vga_vsync;
  logic        vga_de;
  logic        frame_start;
  logic [15:0] pins;

  always #5 clk = ~clk;

  vga_frame_reader #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rd_addr(rd_addr),
    .rd_en(rd_en),
    .rd_data(rd_data),
    .vga_r(vga_r),
    .vga_g(vga_g),
    .vga_b(vga_b),
    .vga_hsync(vga_hsync),
    .vga_vsync(vga_vsync),
    .vga_de(vga_de),
    .frame_start(frame_start)
  );

  assign pins = {vga_de, vga_hsync, vga_vsync, frame_start,
                 vga_r, vga_g, vga_b};

  int vectors = 0;
  int miscompares = 0;
  bit mode = 1'b0;
  int cyc;
  logic [15:0] q[$];
  int nfs = 0;
  int fs_gap = 0;
  bit fs_seen = 1'b0;
  int hs_cnt = 0;
  int vs_cnt = 0;
  int k, f, x, y, ea;
  bit vis;
  logic [15:0] e;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] want);
    vectors++;
    if (obs !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, want, $time);
    end
  endtask

  // synchronous-read frame buffer: mode 0 returns address, mode 1 all-white
  always @(posedge clk) rd_data <= mode ? 12'hFFF : rd_addr[11:0];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_pins", 32'(pins), 32'(BLANK));
      chk("rst_rd", 32'({rd_en, rd_addr}), 32'd0);
      q.delete();
      q.push_back(BLANK);
      q.push_back(BLANK);
      fs_seen = 1'b0;
      fs_gap = 0;
      hs_cnt = 0;
      vs_cnt = 0;
    end else begin
      k = cyc - 1;
      f = k % FRAME;
      x = f % HT;
      y = f / HT;
      vis = (x < HA) && (y < VA);
      ea = (y >= VA) ? VA * HA : y * HA + ((x < HA) ? x : HA);
      chk("rd_port", 32'({rd_en, rd_addr}), 32'({vis, 19'(ea)}));
      e = {vis,
           !((x >= HA + HFP) && (x < HA + HFP + HS)),
           !((y >= VA + VFP) && (y < VA + VFP + VS)),
           (f == 0),
           vis ? (mode ? 12'hFFF : 12'(ea)) : 12'h000};
      q.push_back(e);
      chk("pins", 32'(pins), 32'(q.pop_front()));
      fs_gap++;
      if (frame_start) begin
        nfs++;
        if (fs_seen) chk("fs_period", fs_gap, FRAME);
        fs_seen = 1'b1;
        fs_gap = 0;
      end
      if (!vga_hsync) hs_cnt++;
      else if (hs_cnt != 0) begin
        chk("hs_width", hs_cnt, HS);
        hs_cnt = 0;
      end
      if (!vga_vsync) vs_cnt++;
      else if (vs_cnt != 0) begin
        chk("vs_width", vs_cnt, VS * HT);
        vs_cnt = 0;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2 * FRAME + 5 * HT + 12) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pins", 32'(pins), 32'(BLANK));
    chk("async_rd", 32'({rd_en, rd_addr}), 32'd0);
    mode = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2 * FRAME + 50) @(negedge clk);
    chk("fs_count", nfs, 6);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
